axis_bram_writer: RTL
=====================

# axis_bram_writer

- AXI4-Stream slave that receives one 144-bit beat per pixel and writes it into the nine per-direction BRAM lanes.
- Each beat carries the 9 lattice directions (n, null, ne, e, se, s, sw, w, nw) of one pixel.
- Sits at the inbound end of the lattice-data stream: it is the receiving counterpart to the BRAM-to-stream transmitter and fills the BRAMs that the transmitter later reads.
- Frame length is fixed at DEPTH beats; TLAST and TSTRB are checked for framing errors.

## Interface
- DATA_WIDTH, 16, width of one direction value
- DEPTH, 2500, pixels (beats) per frame
- ADDRESS_WIDTH, 12, BRAM address width; must satisfy 2^ADDRESS_WIDTH >= DEPTH
- s00_axis_aclk  in  1  sole clock; all logic on rising edge
- s00_axis_aresetn  in  1  asynchronous, active-low reset
- frame_start  in  1  arms reception of one frame; honoured only in IDLE
- s00_axis_tvalid  in  1  beat valid
- s00_axis_tready  out  1  beat accepted when high together with tvalid
- s00_axis_tdata  in  144  packed pixel: [143:128]=n, [127:112]=null, [111:96]=ne, [95:80]=e, [79:64]=se, [63:48]=s, [47:32]=sw, [31:16]=w, [15:0]=nw
- s00_axis_tstrb  in  18  byte strobes; expected all ones
- s00_axis_tlast  in  1  end of frame marker
- write_en  out  1  BRAM write enable, shared by all nine lanes
- write_addr  out  ADDRESS_WIDTH  BRAM write address (pixel index)
- n1, null1, ne1, e1, se1, s1, sw1, w1, nw1  out  16 each  per-lane write data
- frame_done  out  1  one-cycle pulse at frame completion
- frame_error  out  1  sticky framing/strobe error flag

## Operation
- States:
  - IDLE: tready=0. frame_start=1 -> RECV; beat_count<=0; frame_error<=0.
  - RECV: tready=1. Each handshake (tvalid & tready) registers tdata into the nine lane outputs, sets write_addr<=beat_count and write_en<=1 for the next cycle, then increments beat_count.
  - DONE: tready=0, frame_done=1 for exactly one cycle, then -> IDLE unconditionally.
- RECV -> DONE on the handshake where beat_count==DEPTH-1, or on a handshake with tlast=1 (whichever comes first).
- frame_error is set by any of:
  - tlast=1 on a beat with beat_count<DEPTH-1: early termination; frame truncated, that beat is still written.
  - tlast=0 on beat DEPTH-1: missing TLAST; frame closes anyway.
  - tstrb != all ones on any accepted beat: beat is still written in full.
- frame_error holds its value until reset or the next accepted frame_start.
- beat_count is ADDRESS_WIDTH wide. It never exceeds DEPTH-1, so no wrap-around occurs inside a frame.
- frame_start in RECV or DONE is ignored; a new frame must not be armed until the block is back in IDLE.
- tvalid in IDLE or DONE is not accepted. Data stays pending upstream per AXIS rules; no data is dropped by this block.
- Reset, including mid-frame: state=IDLE and all outputs 0. A partially written frame is abandoned; BRAM contents are not cleared.

## Timing
- Reset values: tready=0, write_en=0, write_addr=0, all lane outputs=0, frame_done=0, frame_error=0.
- tready is decoded from the registered state only, with no combinational path from tvalid.
- Write latency is 1 cycle: handshake at edge k -> write_en=1 with matching write_addr and data during cycle k+1.
- write_en is low in any cycle not preceded by a handshake.
- Throughput is 1 beat/clock while tvalid is held high; tvalid gaps simply stall, with no state change.
- Final beat at edge k:
  - cycle k+1: state=DONE, frame_done=1, final write_en=1.
  - cycle k+2: IDLE.
- frame_start sampled high in IDLE at edge j -> tready=1 from cycle j+1.
- frame_error rises in the cycle after the offending handshake, coincident with that beat's write_en.

## Test plan
- Nominal frame: frame_start, then 2500 back-to-back beats with tdata = 9 copies of the pixel index and tlast only on beat 2499 -> 2500 writes at addr 0..2499, each lane = index; frame_done pulses once with the last write; frame_error=0.
- Throttled source: tvalid toggled pseudo-randomly over a full frame -> same write sequence with no gaps in addresses and no duplicate writes; write_en count=2500.
- Early tlast: tlast=1 on beat 99 -> writes to addr 0..99 only; frame_done pulses; frame_error=1; tready=0 afterwards; next frame_start clears frame_error.
- Missing tlast and bad strobe: full frame with tlast=0 throughout and tstrb=18'h3FFFE on beat 10 -> all 2500 writes occur; frame_done pulses after beat 2499; frame_error=1.
- Reset mid-frame: assert aresetn=0 after beat 1200 -> all outputs 0 immediately; IDLE with tready=0; a fresh frame_start then writes from addr 0.
- frame_start while busy: pulse frame_start at beat 500 -> ignored; frame completes normally at addr 2499 with a single frame_done.

Source files
------------

// File: rtl/axis_bram_writer_if.sv
// rtl/axis_bram_writer_if.sv - AXI4-Stream beat bus carrying one nine-direction lattice pixel
interface axis_bram_writer_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int TDATA_WIDTH = 9 * DATA_WIDTH;

  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;

  modport master (output tdata, tstrb, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_bram_writer.sv
// rtl/axis_bram_writer.sv - receives a fixed-length pixel frame and writes it into nine BRAM lanes
module axis_bram_writer #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  input  logic                     frame_start,
  axis_bram_writer_if.slave        s00_axis,
  output logic                     write_en,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]    n1,
  output logic [DATA_WIDTH-1:0]    null1,
  output logic [DATA_WIDTH-1:0]    ne1,
  output logic [DATA_WIDTH-1:0]    e1,
  output logic [DATA_WIDTH-1:0]    se1,
  output logic [DATA_WIDTH-1:0]    s1,
  output logic [DATA_WIDTH-1:0]    sw1,
  output logic [DATA_WIDTH-1:0]    w1,
  output logic [DATA_WIDTH-1:0]    nw1,
  output logic                     frame_done,
  output logic                     frame_error
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_BEAT = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDRESS_WIDTH-1:0] beat_count;
  logic                     handshake;
  logic                     last_beat;
  logic                     beat_error;

  // tready comes straight from the registered state so there is no tvalid->tready path
  assign s00_axis.tready = (state == RECV);
  assign frame_done      = (state == DONE);

  assign handshake  = s00_axis.tvalid && (state == RECV);
  assign last_beat  = (beat_count == LAST_BEAT);
  // tlast must coincide exactly with the final beat; any partial strobe also flags the frame
  assign beat_error = (s00_axis.tlast != last_beat) || !(&s00_axis.tstrb);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (frame_start) state_nxt = RECV;
      RECV: if (handshake && (last_beat || s00_axis.tlast)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      write_en    <= 1'b0;
      write_addr  <= '0;
      beat_count  <= '0;
      frame_error <= 1'b0;
      n1          <= '0;
      null1       <= '0;
      ne1         <= '0;
      e1          <= '0;
      se1         <= '0;
      s1          <= '0;
      sw1         <= '0;
      w1          <= '0;
      nw1         <= '0;
    end else begin
      write_en <= handshake;
      if (state == IDLE && frame_start) begin
        beat_count  <= '0;
        frame_error <= 1'b0;
      end
      if (handshake) begin
        write_addr <= beat_count;
        n1         <= s00_axis.tdata[8*DATA_WIDTH +: DATA_WIDTH];
        null1      <= s00_axis.tdata[7*DATA_WIDTH +: DATA_WIDTH];
        ne1        <= s00_axis.tdata[6*DATA_WIDTH +: DATA_WIDTH];
        e1         <= s00_axis.tdata[5*DATA_WIDTH +: DATA_WIDTH];
        se1        <= s00_axis.tdata[4*DATA_WIDTH +: DATA_WIDTH];
        s1         <= s00_axis.tdata[3*DATA_WIDTH +: DATA_WIDTH];
        sw1        <= s00_axis.tdata[2*DATA_WIDTH +: DATA_WIDTH];
        w1         <= s00_axis.tdata[1*DATA_WIDTH +: DATA_WIDTH];
        nw1        <= s00_axis.tdata[0 +: DATA_WIDTH];
        // Closing beat parks the counter at zero so it never reaches DEPTH
        if (last_beat || s00_axis.tlast) begin
          beat_count <= '0;
        end else begin
          beat_count <= beat_count + ADDRESS_WIDTH'(1);
        end
        if (beat_error) begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule
